// File: rtl/uart_tx_arb_if.sv
//------------------------------------------------------------------------------
// Module      : uart_tx_arb_if
// Description : Requester lanes, serializer handshake and status of uart_tx_arb.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface uart_tx_arb_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [8*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_last_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [7:0]           tx_data_o;
    logic                 tx_req_o;
    logic                 tx_idle_i;
    logic [NUM_REQ-1:0]   grant_o;
    logic                 busy_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, tx_idle_i,
        output req_ready_o, tx_data_o, tx_req_o, grant_o, busy_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, tx_idle_i,
        input  req_ready_o, tx_data_o, tx_req_o, grant_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arb.sv
//------------------------------------------------------------------------------
// Module      : uart_tx_arb
// Description : Round-robin packet arbiter feeding one uart_tx through a
//               single-entry holding register.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_tx_arb #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    uart_tx_arb_if.slave  bus
);

    localparam int         c_ptr_w = $clog2(NUM_REQ);
    localparam logic [0:0] c_idle  = 1'b0;
    localparam logic [0:0] c_own   = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_next_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [c_ptr_w-1:0]  r_rr_ptr;
    logic [7:0]          r_burst_cnt;
    logic                r_hold_full;
    logic [7:0]          r_hold_data;

    logic                w_found;
    logic [c_ptr_w-1:0]  w_win_idx;
    int                  w_best;
    int                  w_dist;
    logic [7:0]          w_owner_data;
    logic                w_owner_valid;
    logic                w_owner_last;
    logic                w_accept;
    logic                w_burst_end;
    logic                w_release;
    logic [NUM_REQ-1:0]  w_ready;
    logic                w_busy;

    // Distance 0 is the lane just after rr_ptr; the last owner ranks last.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_best    = NUM_REQ;
        w_dist    = 0;
        for (int n = 0; n < NUM_REQ; n++) begin
            w_dist = (n + NUM_REQ - 1 - int'(r_rr_ptr)) % NUM_REQ;
            if (bus.req_valid_i[n] && (w_dist < w_best)) begin
                w_best    = w_dist;
                w_found   = 1'b1;
                w_win_idx = c_ptr_w'(n);
            end
        end
    end

    always_comb begin
        w_owner_data = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (r_grant[n]) begin
                w_owner_data = bus.req_data_i[8*n +: 8];
            end
        end
    end

    assign w_owner_valid = |(bus.req_valid_i & r_grant);
    assign w_owner_last  = |(bus.req_last_i & r_grant);
    assign w_accept      = (r_state == c_own) && !r_hold_full && w_owner_valid;
    assign w_burst_end   = ({1'b0, r_burst_cnt} + 9'd1) == 9'(MAX_BURST);
    assign w_release     = w_accept && (w_owner_last || w_burst_end);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            c_idle:  if (w_found)   w_next_state = c_own;
            c_own:   if (w_release) w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        w_ready = '0;
        w_busy  = r_hold_full;
        unique case (r_state)
            c_own: begin
                w_ready = r_grant & {NUM_REQ{!r_hold_full}};
                w_busy  = 1'b1;
            end
            default: ;
        endcase
    end

    // Grant, pointer and burst count; rr_ptr doubles as the owner index.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_grant     <= '0;
            r_rr_ptr    <= c_ptr_w'(NUM_REQ - 1);
            r_burst_cnt <= '0;
        end else if (r_state == c_idle) begin
            if (w_found) begin
                r_grant     <= NUM_REQ'(1) << w_win_idx;
                r_rr_ptr    <= w_win_idx;
                r_burst_cnt <= '0;
            end
        end else if (w_accept) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
            if (w_release) begin
                r_grant <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_data <= w_owner_data;
        end else if (r_hold_full && bus.tx_idle_i) begin
            r_hold_full <= 1'b0;
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.busy_o      = w_busy;
    assign bus.grant_o     = r_grant;
    assign bus.tx_req_o    = r_hold_full;
    assign bus.tx_data_o   = r_hold_data;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_tx_arb
// Description : Scoreboard bench for uart_tx_arb (default cap and cap of 4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arb_if #(.NUM_REQ(4)) bus_a ();
    uart_tx_arb_if #(.NUM_REQ(4)) bus_b ();

    uart_tx_arb #(.NUM_REQ(4), .MAX_BURST(16)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a.slave)
    );

    uart_tx_arb #(.NUM_REQ(4), .MAX_BURST(4)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Lane queues hold {last, data}; exp queues hold bytes in serializer order.
    logic [8:0] lane_a [4][$];
    logic [8:0] lane_b [4][$];
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];

    // Requester models and serializer-side scoreboard monitor.
    initial begin
        logic [3:0] hs_a, hs_b;
        logic [7:0] e;
        bus_a.req_valid_i = '0; bus_a.req_data_i = '0; bus_a.req_last_i = '0;
        bus_b.req_valid_i = '0; bus_b.req_data_i = '0; bus_b.req_last_i = '0;
        forever begin
            @(negedge clk);
            hs_a = bus_a.req_valid_i & bus_a.req_ready_o;
            hs_b = bus_b.req_valid_i & bus_b.req_ready_o;
            if (bus_a.tx_req_o && bus_a.tx_idle_i) begin
                n_checks++;
                if (exp_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_a: got byte %02h, expected no transfer", bus_a.tx_data_o);
                end else begin
                    e = exp_a.pop_front();
                    if (bus_a.tx_data_o !== e) begin
                        n_fail++;
                        $display("FAIL sb_a: got %02h expected %02h", bus_a.tx_data_o, e);
                    end
                end
            end
            if (bus_b.tx_req_o && bus_b.tx_idle_i) begin
                n_checks++;
                if (exp_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_b: got byte %02h, expected no transfer", bus_b.tx_data_o);
                end else begin
                    e = exp_b.pop_front();
                    if (bus_b.tx_data_o !== e) begin
                        n_fail++;
                        $display("FAIL sb_b: got %02h expected %02h", bus_b.tx_data_o, e);
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int n = 0; n < 4; n++) begin
                if (hs_a[n] && lane_a[n].size() != 0) void'(lane_a[n].pop_front());
                if (hs_b[n] && lane_b[n].size() != 0) void'(lane_b[n].pop_front());
                bus_a.req_valid_i[n]       = (lane_a[n].size() != 0);
                bus_a.req_data_i[8*n +: 8] = (lane_a[n].size() != 0) ? lane_a[n][0][7:0] : 8'h00;
                bus_a.req_last_i[n]        = (lane_a[n].size() != 0) ? lane_a[n][0][8] : 1'b0;
                bus_b.req_valid_i[n]       = (lane_b[n].size() != 0);
                bus_b.req_data_i[8*n +: 8] = (lane_b[n].size() != 0) ? lane_b[n][0][7:0] : 8'h00;
                bus_b.req_last_i[n]        = (lane_b[n].size() != 0) ? lane_b[n][0][8] : 1'b0;
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic flush_all;
        for (int n = 0; n < 4; n++) begin
            lane_a[n].delete();
            lane_b[n].delete();
        end
        exp_a.delete();
        exp_b.delete();
    endtask

    task automatic do_reset;
        @(posedge clk);
        #2;
        rst = 1'b1;
        flush_all();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_a.size() == 0 && exp_b.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        bit ok;
        #3;
        n_checks++;
        if ({bus_a.req_ready_o, bus_a.tx_data_o, bus_a.tx_req_o, bus_a.grant_o, bus_a.busy_o} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %05h expected 00000",
                     {bus_a.req_ready_o, bus_a.tx_data_o, bus_a.tx_req_o, bus_a.grant_o, bus_a.busy_o});
        end
        n_checks++;
        if (bus_b.grant_o !== 4'b0000 || bus_b.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: got grant %b busy %b expected 0000 0", bus_b.grant_o, bus_b.busy_o);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Hold a byte with the serializer stalled, then reset mid-packet.
        bus_a.tx_idle_i = 1'b0;
        lane_a[1].push_back({1'b0, 8'h11});
        lane_a[1].push_back({1'b1, 8'h12});
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = bus_a.tx_req_o;
        end
        n_checks++;
        if (!ok || bus_a.tx_data_o !== 8'h11 || bus_a.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: got req %b data %02h busy %b expected 1 11 1",
                     bus_a.tx_req_o, bus_a.tx_data_o, bus_a.busy_o);
        end
        #1;
        rst = 1'b1;
        flush_all();
        #1;
        n_checks++;
        if ({bus_a.req_ready_o, bus_a.tx_data_o, bus_a.tx_req_o, bus_a.grant_o, bus_a.busy_o} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %05h expected 00000",
                     {bus_a.req_ready_o, bus_a.tx_data_o, bus_a.tx_req_o, bus_a.grant_o, bus_a.busy_o});
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        bus_a.tx_idle_i = 1'b1;

        lane_a[1].push_back({1'b1, 8'h02});
        lane_a[0].push_back({1'b1, 8'h01});
        exp_a.push_back(8'h01);
        exp_a.push_back(8'h02);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            ok = (bus_a.grant_o != 4'b0000);
        end
        n_checks++;
        if (bus_a.grant_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b expected 0001", bus_a.grant_o);
        end
        wait_drain(50, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_drain: %0d bytes left, expected 0", exp_a.size());
        end
    endtask

    task automatic test_single;
        bit ok;
        bit seen41;
        bit seen42;
        lane_a[2].push_back({1'b0, 8'h41});
        lane_a[2].push_back({1'b1, 8'h42});
        exp_a.push_back(8'h41);
        exp_a.push_back(8'h42);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            ok = (bus_a.grant_o != 4'b0000);
        end
        n_checks++;
        if (bus_a.grant_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_grant: got %b expected 0100", bus_a.grant_o);
        end
        seen41 = 1'b0;
        seen42 = 1'b0;
        for (int i = 0; i < 30 && !seen42; i++) begin
            if (bus_a.tx_req_o && bus_a.tx_data_o == 8'h41 && !seen41) begin
                seen41 = 1'b1;
                n_checks++;
                if (bus_a.grant_o !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL single_mid_grant: got %b expected 0100", bus_a.grant_o);
                end
            end
            if (bus_a.tx_req_o && bus_a.tx_data_o == 8'h42) begin
                seen42 = 1'b1;
                n_checks++;
                if (bus_a.grant_o !== 4'b0000 || bus_a.busy_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_release: got grant %b busy %b expected 0000 1",
                             bus_a.grant_o, bus_a.busy_o);
                end
            end
            if (!seen42) tick();
        end
        n_checks++;
        if (!seen41 || !seen42) begin
            n_fail++;
            $display("FAIL single_seen: got 41=%b 42=%b expected 1 1", seen41, seen42);
        end
        wait_drain(30, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_drain: %0d bytes left, expected 0", exp_a.size());
        end
    endtask

    task automatic test_round_robin;
        bit ok;
        do_reset();
        lane_a[0].push_back({1'b1, 8'hA0});
        lane_a[1].push_back({1'b1, 8'hB1});
        lane_a[3].push_back({1'b1, 8'hD3});
        exp_a.push_back(8'hA0);
        exp_a.push_back(8'hB1);
        exp_a.push_back(8'hD3);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            ok = (bus_a.grant_o != 4'b0000);
        end
        n_checks++;
        if (bus_a.grant_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL rr_first: got %b expected 0001", bus_a.grant_o);
        end
        lane_a[0].push_back({1'b1, 8'hA1});
        exp_a.push_back(8'hA1);
        wait_drain(60, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rr_drain: %0d bytes left, expected 0", exp_a.size());
        end
    endtask

    task automatic test_packet_lock;
        bit ok;
        int viol;
        for (int i = 0; i < 5; i++) begin
            lane_a[0].push_back({(i == 4), 8'hC0 + 8'(i)});
            exp_a.push_back(8'hC0 + 8'(i));
        end
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            ok = (bus_a.grant_o != 4'b0000);
        end
        n_checks++;
        if (bus_a.grant_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL lock_grant0: got %b expected 0001", bus_a.grant_o);
        end
        lane_a[1].push_back({1'b0, 8'hE0});
        lane_a[1].push_back({1'b1, 8'hE1});
        exp_a.push_back(8'hE0);
        exp_a.push_back(8'hE1);
        viol = 0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick();
            if (bus_a.req_ready_o[1] !== 1'b0) viol++;
            ok = bus_a.req_valid_i[0] && bus_a.req_ready_o[0] && bus_a.req_last_i[0];
        end
        n_checks++;
        if (!ok || viol != 0) begin
            n_fail++;
            $display("FAIL lock_hold: got last_seen %b ready1_cycles %0d expected 1 0", ok, viol);
        end
        tick();
        n_checks++;
        if (bus_a.grant_o !== 4'b0000 || bus_a.req_ready_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL lock_gap: got grant %b ready %b expected 0000 0000",
                     bus_a.grant_o, bus_a.req_ready_o);
        end
        tick();
        n_checks++;
        if (bus_a.grant_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL lock_grant1: got %b expected 0010", bus_a.grant_o);
        end
        wait_drain(60, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL lock_drain: %0d bytes left, expected 0", exp_a.size());
        end
    endtask

    task automatic test_burst;
        bit ok;
        for (int i = 0; i < 10; i++) lane_b[0].push_back({1'b0, 8'h80 + 8'(i)});
        lane_b[2].push_back({1'b0, 8'hC0});
        lane_b[2].push_back({1'b1, 8'hC1});
        for (int i = 0; i < 4; i++) exp_b.push_back(8'h80 + 8'(i));
        exp_b.push_back(8'hC0);
        exp_b.push_back(8'hC1);
        for (int i = 4; i < 10; i++) exp_b.push_back(8'h80 + 8'(i));
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick();
            ok = bus_b.tx_req_o && (bus_b.tx_data_o == 8'hC0);
        end
        n_checks++;
        if (!ok || bus_b.grant_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL burst_switch: got seen %b grant %b expected 1 0100", ok, bus_b.grant_o);
        end
        wait_drain(80, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL burst_drain: %0d bytes left, expected 0", exp_b.size());
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int viol;
        bus_a.tx_idle_i = 1'b0;
        lane_a[3].push_back({1'b0, 8'h55});
        lane_a[3].push_back({1'b1, 8'h56});
        exp_a.push_back(8'h55);
        exp_a.push_back(8'h56);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            ok = bus_a.tx_req_o;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_load: got tx_req %b expected 1", bus_a.tx_req_o);
        end
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus_a.tx_req_o !== 1'b1 || bus_a.tx_data_o !== 8'h55 ||
                bus_a.req_ready_o !== 4'b0000 || bus_a.grant_o !== 4'b1000) viol++;
            tick();
        end
        n_checks++;
        if (viol != 0 || exp_a.size() != 2) begin
            n_fail++;
            $display("FAIL bp_stall: got %0d bad cycles, %0d pending expected 0, 2", viol, exp_a.size());
        end
        @(posedge clk);
        #1;
        bus_a.tx_idle_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus_a.tx_req_o !== 1'b0 || exp_a.size() != 1) begin
            n_fail++;
            $display("FAIL bp_one_transfer: got tx_req %b pending %0d expected 0 1",
                     bus_a.tx_req_o, exp_a.size());
        end
        wait_drain(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_drain: %0d bytes left, expected 0", exp_a.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.tx_idle_i = 1'b1;
        bus_b.tx_idle_i = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_burst();
        test_backpressure();
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one `uart_tx` serializer between `NUM_REQ` byte-stream requesters. Each requester sends packets of bytes, with the final byte flagged by `last`. The arbiter locks the serializer to one requester for a whole packet, or until a burst cap is reached, and presents one byte at a time through a single-entry holding register. It sits directly upstream of `uart_tx`: `tx_req_o` drives its `ready_i`, `tx_data_o` drives its `tx_data_i`, and `tx_idle_i` is fed from its `valid_o`.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `MAX_BURST`, default 16: maximum bytes per grant before forced release, 1..255.
- `clk_i` input 1: system clock.
- `rst_i` input 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `req_valid_i` input NUM_REQ: requester n has a byte on its lane.
- `req_data_i` input 8*NUM_REQ: byte lanes; lane n is bits [8n+7:8n].
- `req_last_i` input NUM_REQ: the byte on lane n ends its packet.
- `req_ready_o` output NUM_REQ: lane n byte accepted when `req_valid_i[n] && req_ready_o[n]`.
- `tx_data_o` output 8: byte held for the serializer.
- `tx_req_o` output 1: holding register full; byte offered to the serializer.
- `tx_idle_i` input 1: serializer can accept a byte. A transfer occurs on `tx_req_o && tx_idle_i`.
- `grant_o` output NUM_REQ: one-hot current owner; all-zero when no owner.
- `busy_o` output 1: an owner is locked or the holding register is full.

## Operation
- State machine has two states, IDLE and OWN.
- IDLE:
  - No owner; `req_ready_o` = 0.
  - If any `req_valid_i` bit is set, pick the winner round-robin. The search starts at `rr_ptr+1` mod NUM_REQ.
  - On the next edge: register the one-hot grant, set `rr_ptr` to the winner, clear `burst_cnt`, go to OWN.
- OWN:
  - `req_ready_o[owner]` = `!hold_full`, combinational. All other `req_ready_o` bits are 0.
  - On acceptance: load `hold_data` from the owner lane, set `hold_full`, increment `burst_cnt`.
  - If the accepted byte has `last`, or `burst_cnt+1 == MAX_BURST`: clear the grant and go to IDLE on the same edge.
- Owner dropping `req_valid_i` mid-packet does not release the grant; the lock persists.
- Holding register:
  - `tx_req_o` = `hold_full`; `tx_data_o` = `hold_data`.
  - On transfer, `hold_full` clears on the next edge. `hold_data` keeps its value.
  - Acceptance and transfer never coincide, because ready is gated by `!hold_full`.
- Arbitration in IDLE proceeds while `hold_full` is still set. The new owner simply waits for `hold_full` to clear.
- `burst_cnt` is 8 bits and cleared on every grant. It cannot wrap, because release occurs at MAX_BURST ≤ 255.
- `busy_o` = (state == OWN) || `hold_full`.

## Timing
- Reset, effective asynchronously:
  - State IDLE; `grant_o` = 0, `rr_ptr` = NUM_REQ-1, so requester 0 has first priority.
  - `hold_full` = 0, `hold_data` = 0, `burst_cnt` = 0.
  - All outputs are therefore 0: `req_ready_o`, `tx_data_o`, `tx_req_o`, `grant_o`, `busy_o`.
- Reset mid-packet discards the held byte and the grant. The serializer sees `tx_req_o` fall immediately.
- Pipeline from a request seen in IDLE at cycle 0:
  - Cycle 1: `grant_o` set, `req_ready_o` high.
  - Cycle 2: byte accepted at the cycle 1 edge, `tx_req_o` high.
  - The transfer occurs in cycle 2 if `tx_idle_i`; `req_ready_o` is high again in cycle 3.
- Steady throughput is 1 byte per 2 cycles, or slower under `tx_idle_i` backpressure.
- Re-arbitration after release costs 1 idle cycle (IDLE state) with no `req_ready_o`.
- Simultaneous requests in IDLE: exactly one winner, the nearest index after `rr_ptr`, cyclic.
- A requester that releases is last in priority for the next arbitration.

## Test plan
- Reset: assert `rst_i` mid-packet with `hold_full` = 1 -> all outputs 0 asynchronously. After release, a request on lane 0 is granted first.
- Single packet: lane 2 sends 0x41, 0x42 with last on 0x42 -> `tx_data_o` shows 0x41 then 0x42, with `grant_o` = 0b0100 throughout. The owner is released on the acceptance edge of 0x42.
- Round-robin: lanes 0, 1, 3 each hold a one-byte packet, all valid simultaneously -> serializer receives lane 0, then 1, then 3. Lane 0 is re-requested after its grant and served after lane 3.
- Packet lock: lane 1 requests while lane 0 is mid-way through a 5-byte packet -> lane 1's ready stays 0 until lane 0's last byte is accepted. Lane 1 is granted 2 cycles later.
- Burst cap: MAX_BURST = 4, lane 0 streams 10 bytes without last while lane 2 is waiting -> after byte 4, lane 2 is granted. Lane 0 resumes after lane 2's packet.
- Backpressure: `tx_idle_i` = 0 for 100 cycles with a held byte 0x55 -> `tx_req_o` and `tx_data_o` = 0x55 stable, owner ready stays 0. Exactly one transfer occurs when `tx_idle_i` rises.
